// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter that serialises deposit/withdraw requests onto one account balance.
// Optional macro DAILY_LIMIT_EN adds a per-day withdrawal accumulator and limit check.
module atm_account_arbiter #(
    parameter int              N_REQ        = 4,
    parameter int              BAL_W        = 64,
    parameter int              AMT_W        = 32,
    parameter longint unsigned INIT_BALANCE = 4500,
    parameter longint unsigned DAILY_LIMIT  = 2000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_tipo,
    input  logic [N_REQ*AMT_W-1:0] req_monto,
    input  logic                   nuevo_dia,
    output logic [N_REQ-1:0]       grant,
    output logic                   done,
    output logic                   ok,
    output logic                   fondos_insuficientes,
    output logic                   desborde,
    output logic                   limite_excedido,
    output logic [BAL_W-1:0]       balance,
    output logic                   ocupado
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               done_q, done_d;
    logic               ok_q, ok_d;
    logic               fi_q, fi_d;
    logic               des_q, des_d;
    logic [BAL_W-1:0]   bal_q, bal_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic               tipo_q, tipo_d;
    logic [AMT_W-1:0]   monto_q, monto_d;
    logic [AMT_W-1:0]   monto_arr [N_REQ];
    logic [BAL_W-1:0]   monto_ext;
    logic [BAL_W:0]     sum_dep;
    logic               found;
    logic [PTR_W-1:0]   idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign monto_arr[g] = req_monto[g*AMT_W +: AMT_W];
    end

    assign monto_ext = BAL_W'(monto_q);
    assign sum_dep   = {1'b0, bal_q} + {1'b0, monto_ext};

`ifdef DAILY_LIMIT_EN
    logic [BAL_W-1:0] ret_q, ret_d;
    logic [BAL_W-1:0] ret_eff;
    logic             lim_q, lim_d;
    logic             lim_hit;

    // A new-day pulse coinciding with EXEC clears before the limit is evaluated.
    assign ret_eff = nuevo_dia ? '0 : ret_q;
    assign lim_hit = ({1'b0, ret_eff} + {1'b0, monto_ext}) > (BAL_W+1)'(DAILY_LIMIT);
    assign limite_excedido = lim_q;
`else
    logic unused_nuevo_dia;
    assign unused_nuevo_dia = nuevo_dia;
    assign limite_excedido  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        fi_d    = fi_q;
        des_d   = des_q;
        bal_d   = bal_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        tipo_d  = tipo_q;
        monto_d = monto_q;
        found   = 1'b0;
        idx     = '0;
`ifdef DAILY_LIMIT_EN
        ret_d   = ret_eff;
        lim_d   = lim_q;
`endif
        case (state_q)
            IDLE: begin
                for (int k = 0; k < N_REQ; k++) begin
                    idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        win_d = idx;
                    end
                end
                if (found) begin
                    grant_d = N_REQ'(1) << win_d;
                    tipo_d  = req_tipo[win_d];
                    monto_d = monto_arr[win_d];
                    ok_d    = 1'b0;
                    fi_d    = 1'b0;
                    des_d   = 1'b0;
`ifdef DAILY_LIMIT_EN
                    lim_d   = 1'b0;
`endif
                    ptr_d   = (int'(win_d) == N_REQ - 1) ? '0 : win_d + 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                done_d  = 1'b1;
                state_d = RESP;
                if (!tipo_q) begin
                    if (sum_dep[BAL_W]) begin
                        des_d = 1'b1;
                    end else begin
                        bal_d = sum_dep[BAL_W-1:0];
                        ok_d  = 1'b1;
                    end
                end else if (monto_ext > bal_q) begin
                    fi_d = 1'b1;
                end
`ifdef DAILY_LIMIT_EN
                else if (lim_hit) begin
                    lim_d = 1'b1;
                end
`endif
                else begin
                    bal_d = bal_q - monto_ext;
                    ok_d  = 1'b1;
`ifdef DAILY_LIMIT_EN
                    ret_d = ret_eff + monto_ext;
`endif
                end
            end
            RESP: begin
                if (!req[win_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched request fields carry no reset; they are only read after a grant.
    always_ff @(posedge clk) begin
        win_q   <= win_d;
        tipo_q  <= tipo_d;
        monto_q <= monto_d;
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            fi_q    <= 1'b0;
            des_q   <= 1'b0;
            bal_q   <= BAL_W'(INIT_BALANCE);
            ptr_q   <= '0;
`ifdef DAILY_LIMIT_EN
            ret_q   <= '0;
            lim_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            fi_q    <= fi_d;
            des_q   <= des_d;
            bal_q   <= bal_d;
            ptr_q   <= ptr_d;
`ifdef DAILY_LIMIT_EN
            ret_q   <= ret_d;
            lim_q   <= lim_d;
`endif
        end
    end

    assign grant                = grant_q;
    assign done                 = done_q;
    assign ok                   = ok_q;
    assign fondos_insuficientes = fi_q;
    assign desborde             = des_q;
    assign balance              = bal_q;
    assign ocupado              = (state_q != IDLE);

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed bench for atm_account_arbiter with hand-computed expectations.
// BAL_W is set to 32 so a full-width deposit can reach the overflow boundary.
module tb_atm_account_arbiter;
    localparam int N_REQ = 4;
    localparam int BAL_W = 32;
    localparam int AMT_W = 32;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       req_tipo;
    logic [N_REQ*AMT_W-1:0] req_monto;
    logic                   nuevo_dia;
    logic [N_REQ-1:0]       grant;
    logic                   done;
    logic                   ok;
    logic                   fondos_insuficientes;
    logic                   desborde;
    logic                   limite_excedido;
    logic [BAL_W-1:0]       balance;
    logic                   ocupado;
    logic [AMT_W-1:0]       mon [N_REQ];

    int checks = 0;
    int errors = 0;

    assign req_monto = {mon[3], mon[2], mon[1], mon[0]};

    atm_account_arbiter #(
        .N_REQ(N_REQ), .BAL_W(BAL_W), .AMT_W(AMT_W),
        .INIT_BALANCE(4500), .DAILY_LIMIT(2000)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_tipo(req_tipo), .req_monto(req_monto),
        .nuevo_dia(nuevo_dia), .grant(grant), .done(done), .ok(ok),
        .fondos_insuficientes(fondos_insuficientes), .desborde(desborde),
        .limite_excedido(limite_excedido), .balance(balance), .ocupado(ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // One isolated transaction on port p; leaves the arbiter back in IDLE.
    task automatic txn(input int p, input logic tipo, input logic [31:0] m);
        int lat;
        logic [3:0] g;
        req_tipo[p[1:0]] = tipo;
        mon[p[1:0]]      = m;
        req[p[1:0]]      = 1'b1;
        lat = 0;
        g   = '0;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
            if (grant != 0) g = grant;
        end
        check("txn_latency", 64'(lat), 64'd2);
        check("txn_grant", 64'(g), 64'(4'b0001 << p));
        req[p[1:0]] = 1'b0;
        tick();
        check("txn_release", 64'(grant), 64'd0);
    endtask

    // Waits for the next done with several requesters pending, then releases the winner.
    task automatic serve(input logic [3:0] exp_g, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(grant), 64'(exp_g));
        check({tag, "_ok"}, 64'(ok), 64'd1);
        req = req & ~grant;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_tipo  = '0;
        nuevo_dia = 1'b0;
        for (int i = 0; i < N_REQ; i++) mon[i] = '0;

        // 1: reset state
        do_reset();
        check("rst_balance", 64'(balance), 64'd4500);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_flags", 64'({ok, fondos_insuficientes, desborde, limite_excedido}), 64'd0);
        check("rst_ocupado", 64'(ocupado), 64'd0);

        // 2: port0 deposit 1000, amount change after grant must be ignored
        req_tipo[0] = 1'b0;
        mon[0]      = 32'd1000;
        req[0]      = 1'b1;
        tick();
        check("t2_grant", 64'(grant), 64'b0001);
        check("t2_done_early", 64'(done), 64'd0);
        check("t2_ocupado", 64'(ocupado), 64'd1);
        mon[0] = 32'd7;
        tick();
        check("t2_done", 64'(done), 64'd1);
        check("t2_ok", 64'(ok), 64'd1);
        check("t2_balance", 64'(balance), 64'd5500);
        req[0] = 1'b0;
        tick();
        check("t2_grant_drop", 64'(grant), 64'd0);
        check("t2_done_pulse", 64'(done), 64'd0);
        check("t2_ok_hold", 64'(ok), 64'd1);

        // 3: insufficient funds, exact-balance withdraw, zero amount
        do_reset();
        txn(1, 1'b1, 32'd6000);
        check("t3_fi", 64'(fondos_insuficientes), 64'd1);
        check("t3_fi_ok", 64'(ok), 64'd0);
        check("t3_fi_bal", 64'(balance), 64'd4500);
        txn(1, 1'b1, 32'd4500);
        check("t3_exact_ok", 64'(ok), 64'd1);
        check("t3_exact_fi", 64'(fondos_insuficientes), 64'd0);
        check("t3_exact_bal", 64'(balance), 64'd0);
        txn(2, 1'b1, 32'd1);
        check("t3_empty_fi", 64'(fondos_insuficientes), 64'd1);
        txn(2, 1'b0, 32'd0);
        check("t3_zero_ok", 64'(ok), 64'd1);
        check("t3_zero_bal", 64'(balance), 64'd0);

        // 4: round-robin across all ports, then 0+2 with pointer back at 0
        do_reset();
        req_tipo = 4'b1111;
        for (int i = 0; i < N_REQ; i++) mon[i] = 32'd1;
        req = 4'b1111;
        serve(4'b0001, "t4_rr0");
        serve(4'b0010, "t4_rr1");
        serve(4'b0100, "t4_rr2");
        serve(4'b1000, "t4_rr3");
        req = 4'b0101;
        serve(4'b0001, "t4_pair0");
        serve(4'b0100, "t4_pair2");
        check("t4_balance", 64'(balance), 64'd4494);

        // 5: overflow, deposit to the exact top, reset during EXEC
        do_reset();
        txn(2, 1'b0, 32'hFFFF_FFFF);
        check("t5_desborde", 64'(desborde), 64'd1);
        check("t5_des_ok", 64'(ok), 64'd0);
        check("t5_des_bal", 64'(balance), 64'd4500);
        txn(2, 1'b0, 32'hFFFF_EE6B);
        check("t5_top_ok", 64'(ok), 64'd1);
        check("t5_top_bal", 64'(balance), 64'hFFFF_FFFF);
        do_reset();
        req_tipo[3] = 1'b0;
        mon[3]      = 32'd100;
        req[3]      = 1'b1;
        tick();
        check("t5_mid_grant", 64'(grant), 64'b1000);
        rst = 1'b0;
        tick();
        check("t5_mid_done", 64'(done), 64'd0);
        check("t5_mid_grant_clr", 64'(grant), 64'd0);
        check("t5_mid_bal", 64'(balance), 64'd4500);
        check("t5_mid_ocupado", 64'(ocupado), 64'd0);
        rst    = 1'b1;
        req[3] = 1'b0;
        tick();
        check("t5_after_done", 64'(done), 64'd0);
        check("t5_after_bal", 64'(balance), 64'd4500);

        // 6: daily withdrawal limit
        do_reset();
        txn(0, 1'b1, 32'd1500);
        check("t6_first_ok", 64'(ok), 64'd1);
        check("t6_first_bal", 64'(balance), 64'd3000);
        txn(0, 1'b1, 32'd600);
`ifdef DAILY_LIMIT_EN
        check("t6_lim", 64'(limite_excedido), 64'd1);
        check("t6_lim_ok", 64'(ok), 64'd0);
        check("t6_lim_bal", 64'(balance), 64'd3000);
        nuevo_dia = 1'b1;
        tick();
        nuevo_dia = 1'b0;
        txn(0, 1'b1, 32'd600);
        check("t6_newday_ok", 64'(ok), 64'd1);
        check("t6_newday_lim", 64'(limite_excedido), 64'd0);
        check("t6_newday_bal", 64'(balance), 64'd2400);
`else
        check("t6_nolim_ok", 64'(ok), 64'd1);
        check("t6_nolim_flag", 64'(limite_excedido), 64'd0);
        check("t6_nolim_bal", 64'(balance), 64'd2400);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
